// File: rtl/locked_adder_key_sweep_ctrl.sv
// Purpose : per-key sweep of NVEC operand pairs through a logic-locked adder, counting wrong vectors and wrong bits.
// Latency : report valid NVEC+3 cycles after the key handshake; vector data is registered 1 cycle after its address.
// Backpressure: one key at a time (key_ready only in IDLE); the report is held stable until res_ready.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   key_valid_i/key_i        key offer; key_ready_o accepts it (IDLE only)
//   vec_rd_o/vec_addr_o      vector RAM read port; vec_a_i/vec_b_i return one cycle later
//   add1_o/add2_o/keyinput_o registered drive into the locked adder; result_i is its output
//   res_valid_o/res_ready_i  report handshake carrying err_vec_o, err_bits_o and res_key_o
//   busy_o                   high whenever a key is being processed or reported
module locked_adder_key_sweep_ctrl #(
  parameter int WIDTH = 32,
  parameter int KEYW  = 64,
  parameter int NVEC  = 10000,
  parameter int AW    = 14,
  parameter int CNTW  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid_i,
  input  logic [KEYW-1:0]  key_i,
  output logic             key_ready_o,
  output logic             vec_rd_o,
  output logic [AW-1:0]    vec_addr_o,
  input  logic [WIDTH-1:0] vec_a_i,
  input  logic [WIDTH-1:0] vec_b_i,
  output logic [WIDTH-1:0] add1_o,
  output logic [WIDTH-1:0] add2_o,
  output logic [KEYW-1:0]  keyinput_o,
  input  logic [WIDTH:0]   result_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [CNTW-1:0]  err_vec_o,
  output logic [CNTW-1:0]  err_bits_o,
  output logic [KEYW-1:0]  res_key_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

  localparam logic [AW-1:0]   LAST_ADDR = AW'(NVEC - 1);
  localparam logic [CNTW-1:0] CNT_MAX   = '1;
  // popcount of a WIDTH+1 bit word needs PCW bits; EW leaves room so the
  // saturating add can detect overflow even when CNTW is tiny.
  localparam int PCW = $clog2(WIDTH + 2);
  localparam int EW  = ((CNTW > PCW) ? CNTW : PCW) + 1;

  state_t state;
  logic   drain_cnt;
  logic   ld_vld;   // RAM data for an issued address is on vec_a_i/vec_b_i
  logic   cmp_vld;  // add1_o/add2_o hold a vector whose result is on result_i

  logic [WIDTH:0]  golden;
  logic [WIDTH:0]  diff;
  logic [PCW-1:0]  pcnt;
  logic [EW-1:0]   bits_sum;
  logic [CNTW-1:0] err_vec_nxt;
  logic [CNTW-1:0] err_bits_nxt;

  always_comb begin
    golden = {1'b0, add1_o} + {1'b0, add2_o};
    diff   = result_i ^ golden;
    pcnt   = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      pcnt = pcnt + PCW'(diff[i]);
    end
    bits_sum     = EW'(err_bits_o) + EW'(pcnt);
    err_bits_nxt = (bits_sum > EW'(CNT_MAX)) ? CNT_MAX : bits_sum[CNTW-1:0];
    err_vec_nxt  = err_vec_o;
    if ((diff != '0) && (err_vec_o != CNT_MAX)) begin
      err_vec_nxt = err_vec_o + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      drain_cnt  <= 1'b0;
      ld_vld     <= 1'b0;
      cmp_vld    <= 1'b0;
      vec_addr_o <= '0;
      add1_o     <= '0;
      add2_o     <= '0;
      keyinput_o <= '0;
      res_key_o  <= '0;
      err_vec_o  <= '0;
      err_bits_o <= '0;
    end else begin
      ld_vld  <= (state == RUN);
      cmp_vld <= ld_vld;
      if (ld_vld) begin
        add1_o <= vec_a_i;
        add2_o <= vec_b_i;
      end
      if (cmp_vld) begin
        err_vec_o  <= err_vec_nxt;
        err_bits_o <= err_bits_nxt;
      end

      case (state)
        IDLE: begin
          if (key_valid_i) begin
            keyinput_o <= key_i;
            res_key_o  <= key_i;
            vec_addr_o <= '0;
            err_vec_o  <= '0;
            err_bits_o <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (vec_addr_o == LAST_ADDR) begin
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else begin
            vec_addr_o <= vec_addr_o + AW'(1);
          end
        end
        // two cycles let the last issued vector reach the counters
        DRAIN: begin
          if (drain_cnt) begin
            state <= REPORT;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        REPORT: begin
          if (res_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign key_ready_o = (state == IDLE);
  assign vec_rd_o    = (state == RUN);
  assign res_valid_o = (state == REPORT);
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_locked_adder_key_sweep_ctrl.sv
// Bench for the key-sweep sequencer: a main DUT (CNTW=32) and a narrow-counter DUT (CNTW=2) run in lockstep.
module tb_locked_adder_key_sweep_ctrl;

  localparam int W = 32;
  localparam int K = 64;
  localparam int N = 4;
  localparam int A = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          key_valid = 1'b0;
  logic [K-1:0]  key = '0;
  logic          res_ready = 1'b0;
  logic [W-1:0]  vec_a = '0, vec_b = '0;

  logic          key_ready, vec_rd, res_valid, busy;
  logic [A-1:0]  vec_addr;
  logic [W-1:0]  add1, add2;
  logic [K-1:0]  keyinput, res_key;
  logic [W:0]    result;
  logic [31:0]   err_vec, err_bits;

  logic          key_ready2, vec_rd2, res_valid2, busy2;
  logic [A-1:0]  vec_addr2;
  logic [W-1:0]  add1_2, add2_2;
  logic [K-1:0]  keyinput2, res_key2;
  logic [W:0]    result2;
  logic [1:0]    err_vec2, err_bits2;

  int mode = 0;

  locked_adder_key_sweep_ctrl #(.WIDTH(W), .KEYW(K), .NVEC(N), .AW(A), .CNTW(32)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid_i(key_valid), .key_i(key), .key_ready_o(key_ready),
    .vec_rd_o(vec_rd), .vec_addr_o(vec_addr), .vec_a_i(vec_a), .vec_b_i(vec_b),
    .add1_o(add1), .add2_o(add2), .keyinput_o(keyinput), .result_i(result),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .err_vec_o(err_vec),
    .err_bits_o(err_bits), .res_key_o(res_key), .busy_o(busy));

  locked_adder_key_sweep_ctrl #(.WIDTH(W), .KEYW(K), .NVEC(N), .AW(A), .CNTW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .key_valid_i(key_valid), .key_i(key), .key_ready_o(key_ready2),
    .vec_rd_o(vec_rd2), .vec_addr_o(vec_addr2), .vec_a_i(vec_a), .vec_b_i(vec_b),
    .add1_o(add1_2), .add2_o(add2_2), .keyinput_o(keyinput2), .result_i(result2),
    .res_valid_o(res_valid2), .res_ready_i(res_ready), .err_vec_o(err_vec2),
    .err_bits_o(err_bits2), .res_key_o(res_key2), .busy_o(busy2));

  logic [W-1:0] mem_a [N];
  logic [W-1:0] mem_b [N];
  initial begin
    mem_a[0] = 32'h0000_0001; mem_b[0] = 32'h0000_0002;
    mem_a[1] = 32'hFFFF_FFFF; mem_b[1] = 32'h0000_0001;
    mem_a[2] = 32'h0000_0000; mem_b[2] = 32'h0000_0000;
    mem_a[3] = 32'h7FFF_FFFF; mem_b[3] = 32'h7FFF_FFFF;
  end

  // vector RAM: one-cycle read latency
  always @(posedge clk) begin
    if (vec_rd) begin
      vec_a <= mem_a[vec_addr];
      vec_b <= mem_b[vec_addr];
    end
  end

  // 0: correct adder, 1: flips bits 32,1,0, 2: flips bit 0 only when a==FFFFFFFF
  function automatic logic [W:0] adder_model(input logic [W-1:0] a, input logic [W-1:0] b, input int m);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (m == 1) s = s ^ 33'h1_0000_0003;
    else if (m == 2 && a == 32'hFFFF_FFFF) s = s ^ 33'h1;
    return s;
  endfunction

  always_comb result  = adder_model(add1, add2, mode);
  always_comb result2 = adder_model(add1_2, add2_2, 1);

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] ev;
    logic [31:0] eb;
    logic [63:0] k;
  } exp_t;
  exp_t q_main[$];
  exp_t q_sat[$];

  task automatic push_exp(input logic [63:0] k, input int m);
    exp_t e, s;
    logic [W:0] g, r;
    e.ev = 0; e.eb = 0; e.k = k;
    s.ev = 0; s.eb = 0; s.k = k;
    for (int i = 0; i < N; i++) begin
      g = {1'b0, mem_a[i]} + {1'b0, mem_b[i]};
      r = adder_model(mem_a[i], mem_b[i], m);
      if (r != g) e.ev++;
      e.eb += $countones(r ^ g);
      r = adder_model(mem_a[i], mem_b[i], 1);
      if (r != g) s.ev++;
      s.eb += $countones(r ^ g);
    end
    if (s.ev > 3) s.ev = 3;
    if (s.eb > 3) s.eb = 3;
    q_main.push_back(e);
    q_sat.push_back(s);
  endtask

  // operands must reach add1/add2 two cycles after their address is issued
  logic         h1_rd = 1'b0, h2_rd = 1'b0;
  logic [A-1:0] h1_addr = '0, h2_addr = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      h1_rd <= 1'b0; h2_rd <= 1'b0;
    end else begin
      if (h2_rd) begin
        check_val("align_add1", 64'(add1), 64'(mem_a[h2_addr]));
        check_val("align_add2", 64'(add2), 64'(mem_b[h2_addr]));
      end
      h2_rd <= h1_rd; h2_addr <= h1_addr;
      h1_rd <= vec_rd; h1_addr <= vec_addr;
    end
  end

  task automatic check_reset_vals();
    check_val("rst_key_ready", 64'(key_ready), 64'(1));
    check_val("rst_vec_rd", 64'(vec_rd), 64'(0));
    check_val("rst_vec_addr", 64'(vec_addr), 64'(0));
    check_val("rst_add1", 64'(add1), 64'(0));
    check_val("rst_add2", 64'(add2), 64'(0));
    check_val("rst_keyinput", keyinput, 64'(0));
    check_val("rst_res_key", res_key, 64'(0));
    check_val("rst_res_valid", 64'(res_valid), 64'(0));
    check_val("rst_err_vec", 64'(err_vec), 64'(0));
    check_val("rst_err_bits", 64'(err_bits), 64'(0));
    check_val("rst_busy", 64'(busy), 64'(0));
    check_val("rst_sat_err_vec", 64'(err_vec2), 64'(0));
  endtask

  int acc_cyc;

  task automatic send_key(input logic [63:0] k);
    int n;
    @(posedge clk); #1;
    key_valid = 1'b1; key = k;
    n = 0;
    @(negedge clk);
    while (!key_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("key_ready_seen", 64'(key_ready), 64'(1));
    acc_cyc = cyc;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  // wait for the report, compare against the scoreboard, then consume it
  // after 'hold' cycles of backpressure during which a competing key is offered
  task automatic collect(input int hold, input logic [63:0] other_key);
    int n;
    exp_t e, s;
    logic [31:0] ev0, eb0;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("report_seen", 64'(res_valid), 64'(1));
    check_val("report_latency", 64'(cyc - acc_cyc), 64'(N + 3));
    if (q_main.size() == 0 || q_sat.size() == 0) begin
      check_val("scoreboard_empty", 64'(q_main.size()), 64'(1));
    end else begin
      e = q_main.pop_front();
      s = q_sat.pop_front();
      check_val("err_vec", 64'(err_vec), 64'(e.ev));
      check_val("err_bits", 64'(err_bits), 64'(e.eb));
      check_val("res_key", res_key, e.k);
      check_val("keyinput", keyinput, e.k);
      check_val("sat_err_vec", 64'(err_vec2), 64'(s.ev));
      check_val("sat_err_bits", 64'(err_bits2), 64'(s.eb));
      check_val("hold_add1", 64'(add1), 64'(mem_a[N-1]));
    end
    ev0 = err_vec; eb0 = err_bits;
    if (hold > 0) begin
      key_valid = 1'b1; key = other_key;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("bp_res_valid", 64'(res_valid), 64'(1));
      check_val("bp_key_ready", 64'(key_ready), 64'(0));
      check_val("bp_err_vec", 64'(err_vec), 64'(ev0));
      check_val("bp_err_bits", 64'(err_bits), 64'(eb0));
      check_val("bp_keyinput", keyinput, e.k);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    check_val("handshake_valid", 64'(res_valid), 64'(1));
    @(posedge clk); #1;
    res_ready = 1'b0;
    key_valid = 1'b0;
    @(negedge clk);
    check_val("post_key_ready", 64'(key_ready), 64'(1));
    check_val("post_res_valid", 64'(res_valid), 64'(0));
    check_val("post_busy", 64'(busy), 64'(0));
    check_val("post_keyinput", keyinput, e.k);
  endtask

  task automatic run_key(input logic [63:0] k, input int m, input int hold);
    mode = m;
    push_exp(k, m);
    send_key(k);
    collect(hold, ~k);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals();

    run_key(64'hED06_C024_C5BF_39E2, 0, 0);
    run_key(64'h0123_4567_89AB_CDEF, 1, 0);
    run_key(64'hFEDC_BA98_7654_3210, 0, 0);
    run_key(64'hA5A5_5A5A_0F0F_F0F0, 2, 0);
    run_key(64'h1111_2222_3333_4444, 1, 20);

    // reset pulse during the third RUN cycle discards the key and in-flight vectors
    mode = 0;
    send_key(64'hDEAD_BEEF_CAFE_F00D);
    @(posedge clk);
    @(posedge clk); #1;
    check_val("midrun_rd", 64'(vec_rd), 64'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals();
    run_key(64'h5555_AAAA_5555_AAAA, 1, 0);

    check_val("scoreboard_drained", 64'(q_main.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
